// File: rtl/pwls_sweep_scheduler.sv
// Shares the ALU-unit register write port between a 1-entry CPU write buffer and a pitch-sweep engine.
// Build option: define PWLS_SWEEP_SAT_EN to saturate sweep results instead of wrapping them.
module pwls_sweep_scheduler #(
  parameter int NUM_CHANNELS     = 4,
  parameter int REGS_PER_CHANNEL = 8,
  parameter int REG_BITS         = 16,
  parameter int SWEEP_REG        = 0,
  parameter int DIV_BITS         = 16,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int IDX_W = (REGS_PER_CHANNEL > 1) ? $clog2(REGS_PER_CHANNEL) : 1,
  localparam int A     = CH_W + IDX_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_we,
  input  logic [A-1:0]        cpu_waddr,
  input  logic [REG_BITS-1:0] cpu_wdata,
  output logic                cpu_ready,
  input  logic                step_we,
  input  logic [CH_W-1:0]     step_ch,
  input  logic [7:0]          step_val,
  input  logic [DIV_BITS-1:0] tick_div,
  input  logic                sweep_en,
  input  logic                ovr_clr,
  output logic                overrun,
  output logic                reg_we,
  output logic [A-1:0]        reg_waddr,
  output logic [REG_BITS-1:0] reg_wdata
);

  localparam int EW = REG_BITS + 2;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                r_state, w_state_next;
  logic [CH_W-1:0]       r_ch, w_ch_next;
  logic [DIV_BITS-1:0]   r_presc;
  logic                  w_tick;

  logic signed [7:0]     r_step   [NUM_CHANNELS];
  logic [REG_BITS-1:0]   r_shadow [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_step_nz;

  logic                  r_buf_valid;
  logic [A-1:0]          r_buf_addr;
  logic [REG_BITS-1:0]   r_buf_data;

  logic                  r_last_sweep;
  logic                  r_overrun;
  logic                  r_reg_we;
  logic [A-1:0]          r_reg_waddr;
  logic [REG_BITS-1:0]   r_reg_wdata;

  logic                  w_cpu_req, w_sw_req;
  logic                  w_grant_cpu, w_grant_sw, w_any_grant;
  logic                  w_cpu_accept;
  logic [A-1:0]          w_cpu_addr, w_sw_addr, w_win_addr;
  logic [REG_BITS-1:0]   w_cpu_data, w_win_data, w_cand;
  logic signed [EW-1:0]  w_sum;
  logic [CH_W-1:0]       w_win_ch;
  logic [IDX_W-1:0]      w_win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_step_nz
      assign w_step_nz[gi] = (r_step[gi] != 8'sd0);
    end
  endgenerate

  assign w_tick = sweep_en && (r_presc >= tick_div);

  // Candidate is recomputed every cycle from the live shadow, so a CPU re-seed granted first is picked up.
  assign w_sum = $signed({2'b00, r_shadow[r_ch]}) + EW'(r_step[r_ch]);
`ifdef PWLS_SWEEP_SAT_EN
  always_comb begin
    w_cand = w_sum[REG_BITS-1:0];
    if (w_sum[EW-1])
      w_cand = '0;
    else if (w_sum[EW-2])
      w_cand = '1;
  end
`else
  assign w_cand = w_sum[REG_BITS-1:0];
`endif

  assign w_sw_addr = {r_ch, IDX_W'(SWEEP_REG)};

  // An incoming CPU write bypasses the buffer when it is empty, giving 1-cycle uncontended latency.
  assign w_cpu_req  = r_buf_valid || cpu_we;
  assign w_cpu_addr = r_buf_valid ? r_buf_addr : cpu_waddr;
  assign w_cpu_data = r_buf_valid ? r_buf_data : cpu_wdata;

  assign w_grant_cpu  = w_cpu_req && (!w_sw_req || r_last_sweep);
  assign w_grant_sw   = w_sw_req && !w_grant_cpu;
  assign w_any_grant  = w_grant_cpu || w_grant_sw;
  assign cpu_ready    = !r_buf_valid || w_grant_cpu;
  assign w_cpu_accept = cpu_we && cpu_ready;

  assign w_win_addr = w_grant_cpu ? w_cpu_addr : w_sw_addr;
  assign w_win_data = w_grant_cpu ? w_cpu_data : w_cand;
  assign w_win_ch   = w_win_addr[A-1:IDX_W];
  assign w_win_idx  = w_win_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_next = S_SCAN;
          w_ch_next    = '0;
        end
      end
      S_SCAN: begin
        if (!w_sw_req || w_grant_sw) begin
          if (r_ch == CH_W'(NUM_CHANNELS - 1)) begin
            w_state_next = S_IDLE;
            w_ch_next    = '0;
          end else begin
            w_ch_next = r_ch + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ch_next    = '0;
      end
    endcase
  end

  always_comb begin
    w_sw_req = (r_state == S_SCAN) && w_step_nz[r_ch];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_buf_valid  <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_data   <= '0;
      r_last_sweep <= 1'b1;
      r_overrun    <= 1'b0;
      r_reg_we     <= 1'b0;
      r_reg_waddr  <= '0;
      r_reg_wdata  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_step[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (!sweep_en || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;

      if (w_grant_cpu) begin
        r_buf_valid <= r_buf_valid && cpu_we;
        r_buf_addr  <= cpu_waddr;
        r_buf_data  <= cpu_wdata;
      end else if (w_cpu_accept) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= cpu_waddr;
        r_buf_data  <= cpu_wdata;
      end

      r_reg_we <= w_any_grant;
      if (w_any_grant) begin
        r_reg_waddr  <= w_win_addr;
        r_reg_wdata  <= w_win_data;
        r_last_sweep <= w_grant_sw;
        if (w_win_idx == IDX_W'(SWEEP_REG))
          r_shadow[w_win_ch] <= w_win_data;
      end

      if (step_we)
        r_step[step_ch] <= step_val;

      if (ovr_clr)
        r_overrun <= 1'b0;
      else if (w_tick && (r_state == S_SCAN))
        r_overrun <= 1'b1;
    end
  end

  assign overrun   = r_overrun;
  assign reg_we    = r_reg_we;
  assign reg_waddr = r_reg_waddr;
  assign reg_wdata = r_reg_wdata;

endmodule

// File: tb/tb_pwls_sweep_scheduler.sv
// Self-checking bench for pwls_sweep_scheduler: directed scenarios plus random traffic against a queue-based
// cycle reference model. Honours PWLS_SWEEP_SAT_EN when defined.
module tb_pwls_sweep_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        step_we;
  logic [1:0]  step_ch;
  logic [7:0]  step_val;
  logic [15:0] tick_div;
  logic        sweep_en;
  logic        ovr_clr;
  logic        overrun;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [15:0] reg_wdata;

  always #5 clk = ~clk;

  pwls_sweep_scheduler dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .step_we(step_we), .step_ch(step_ch), .step_val(step_val),
    .tick_div(tick_div), .sweep_en(sweep_en), .ovr_clr(ovr_clr), .overrun(overrun),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending CPU writes in a queue, sweep engine as plain integers.
  typedef struct { int addr; int data; } wr_t;
  wr_t m_q[$];
  int  m_presc, m_ch;
  bit  m_scan, m_last_sweep, m_ovr, m_we;
  int  m_addr, m_data;
  int  m_step[4];
  int  m_shadow[4];

  function automatic int calc(int sh, int st);
    int v;
    v = sh + st;
`ifdef PWLS_SWEEP_SAT_EN
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
    return v;
`else
    return v & 32'hFFFF;
`endif
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_presc = 0; m_ch = 0; m_scan = 0; m_last_sweep = 1; m_ovr = 0;
    m_we = 0; m_addr = 0; m_data = 0;
    for (int i = 0; i < 4; i++) begin
      m_step[i] = 0;
      m_shadow[i] = 0;
    end
  endfunction

  task automatic model_step();
    bit qe, cpu_has, sw_req, cpu_win, sw_win, rdy, tick, was_scan;
    wr_t head;
    int wa, wd, cand;
    qe = (m_q.size() == 0);
    cpu_has = !qe || cpu_we;
    if (!qe) head = m_q[0];
    else begin head.addr = int'(cpu_waddr); head.data = int'(cpu_wdata); end
    sw_req  = m_scan && (m_step[m_ch] != 0);
    cpu_win = cpu_has && (!sw_req || m_last_sweep);
    sw_win  = sw_req && !cpu_win;
    rdy     = qe || cpu_win;
    chk("cpu_ready", cpu_ready, rdy);
    cand = calc(m_shadow[m_ch], m_step[m_ch]);
    wa = 0; wd = 0;
    if (cpu_win) begin
      wa = head.addr; wd = head.data;
      if (!qe) void'(m_q.pop_front());
    end else if (sw_win) begin
      wa = m_ch * 8; wd = cand;
    end
    if (cpu_we && rdy && !(cpu_win && qe)) begin
      head.addr = int'(cpu_waddr); head.data = int'(cpu_wdata);
      m_q.push_back(head);
    end
    m_we = cpu_win || sw_win;
    if (m_we) begin
      m_addr = wa; m_data = wd;
      if (wa % 8 == 0) m_shadow[wa / 8] = wd;
      m_last_sweep = sw_win;
    end
    tick = sweep_en && (m_presc == int'(tick_div));
    was_scan = m_scan;
    if (!m_scan) begin
      if (tick) begin m_scan = 1; m_ch = 0; end
    end else if (!sw_req || sw_win) begin
      if (m_ch == 3) begin m_scan = 0; m_ch = 0; end
      else m_ch++;
    end
    if (ovr_clr) m_ovr = 0;
    else if (tick && was_scan) m_ovr = 1;
    m_presc = (!sweep_en || tick) ? 0 : m_presc + 1;
    if (step_we) m_step[step_ch] = int'($signed(step_val));
    if (reset) model_reset();
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    chk("reg_we", reg_we, m_we);
    chk("reg_waddr", reg_waddr, m_addr);
    chk("reg_wdata", reg_wdata, m_data);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic set_step(input int ch, input int val);
    step_we = 1; step_ch = 2'(ch); step_val = 8'(val);
    cyc();
    step_we = 0;
  endtask

  task automatic cpu_write(input int addr, input int data);
    cpu_we = 1; cpu_waddr = 5'(addr); cpu_wdata = 16'(data);
    cyc();
    cpu_we = 0;
  endtask

  initial begin
    int exp_d, nw, hit;
    int tds[5] = '{0, 1, 3, 7, 20};
    int svs[8] = '{0, 1, -1, 16, -16, -5, 127, -128};

    reset = 1; cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0; step_we = 0; step_ch = 0;
    step_val = 0; tick_div = 0; sweep_en = 0; ovr_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_reg_we", reg_we, 0);
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_waddr", reg_waddr, 0);
    reset = 0;
    cyc();

    // 1: uncontended CPU write appears the next cycle
    cpu_write(5'h09, 16'h1234);
    chk("t1_we", reg_we, 1);
    chk("t1_addr", reg_waddr, 5'h09);
    chk("t1_data", reg_wdata, 16'h1234);
    cyc();

    // 2: single swept channel ramps by +16 from 0x0100
    cpu_write(5'h10, 16'h0100);
    set_step(2, 16);
    tick_div = 3; sweep_en = 1;
    exp_d = 16'h0110; nw = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (reg_we) begin
        chk("t2_addr", reg_waddr, 5'h10);
        chk("t2_data", reg_wdata, exp_d);
        exp_d += 16; nw++;
      end
    end
    chk("t2_some_writes", nw >= 3, 1);

    // 3: all channels swept while the CPU writes every cycle
    sweep_en = 0; cyc();
    for (int c = 0; c < 4; c++) set_step(c, 1);
    tick_div = 20; sweep_en = 1;
    for (int i = 0; i < 40; i++) begin
      cpu_we = 1; cpu_waddr = 5'($urandom_range(0, 31)); cpu_wdata = 16'($urandom);
      cyc();
    end
    cpu_we = 0;
    repeat (3) cyc();

    // 4: tick every cycle overruns; clear then re-assert
    sweep_en = 0; cyc();
    tick_div = 0; sweep_en = 1;
    for (int i = 0; i < 20; i++) begin
      cpu_we = 1'($urandom_range(0, 1)); cpu_waddr = 5'($urandom); cpu_wdata = 16'($urandom);
      cyc();
    end
    cpu_we = 0;
    chk("t4_overrun_set", overrun, 1);
    ovr_clr = 1; cyc(); ovr_clr = 0;
    chk("t4_overrun_clr", overrun, 0);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc();
      if (overrun) hit = 1;
    end
    chk("t4_reassert", hit, 1);

    // 5: 0x0003 + (-5)
    sweep_en = 0; cyc();
    for (int c = 0; c < 4; c++) set_step(c, 0);
    cpu_write(5'h08, 16'h0003);
    set_step(1, -5);
    tick_div = 5; sweep_en = 1;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc();
      if (reg_we) begin
        hit = 1;
        chk("t5_addr", reg_waddr, 5'h08);
`ifdef PWLS_SWEEP_SAT_EN
        chk("t5_data", reg_wdata, 16'h0000);
`else
        chk("t5_data", reg_wdata, 16'hFFFE);
`endif
      end
    end
    chk("t5_seen", hit, 1);

    // 6: reset mid-scan with the buffer holding a write
    sweep_en = 0; cyc();
    for (int c = 0; c < 4; c++) set_step(c, 1);
    tick_div = 2; sweep_en = 1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cpu_we = 1; cpu_waddr = 5'($urandom); cpu_wdata = 16'($urandom);
      cyc();
      if (m_scan && m_q.size() == 1) hit = 1;
    end
    chk("t6_reached", hit, 1);
    reset = 1; cpu_we = 0; cyc();
    reset = 0; sweep_en = 0;
    chk("t6_we", reg_we, 0);
    chk("t6_addr", reg_waddr, 0);
    chk("t6_data", reg_wdata, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_ready", cpu_ready, 1);
    repeat (10) cyc();

    // Random traffic in phases of fixed tick period
    for (int p = 0; p < 8; p++) begin
      sweep_en = 0; tick_div = 16'(tds[$urandom_range(0, 4)]);
      cpu_we = 0; step_we = 0; ovr_clr = 0;
      cyc();
      for (int i = 0; i < 150; i++) begin
        reset    = ($urandom_range(0, 299) == 0);
        sweep_en = ($urandom_range(0, 19) != 0);
        cpu_we   = ($urandom_range(0, 99) < 20 + p * 10);
        cpu_waddr = 5'($urandom);
        if ($urandom_range(0, 1) == 0) cpu_waddr[2:0] = 3'd0;
        cpu_wdata = 16'($urandom);
        step_we  = ($urandom_range(0, 19) == 0);
        step_ch  = 2'($urandom);
        step_val = 8'(svs[$urandom_range(0, 7)]);
        ovr_clr  = ($urandom_range(0, 19) == 0);
        cyc();
      end
    end
    reset = 0; cpu_we = 0; step_we = 0; ovr_clr = 0; sweep_en = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
